// File: rtl/stage_5_byte_packer.sv
// Purpose: packs 0..5 bytes per cycle into a circular byte FIFO with a frame-end tag, and presents the bytes one at a time.
// Latency: a byte written on one edge is visible at the output (show-ahead) right after that edge.
// Backpressure: out_ready stalls pops; a group that does not fit is dropped whole and out_overflow is set.
module stage_5_byte_packer #(
  parameter int S5_BITSTREAM_WIDTH = 8,
  parameter int S5_FIFO_DEPTH      = 16,
  parameter int S5_ADDR_WIDTH      = 4
) (
  input  logic                          s5_clk,
  input  logic                          s5_reset,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_1,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_2,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_3,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_4,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_5,
  input  logic [2:0]                    in_flag,
  input  logic                          in_flag_last,
  output logic [S5_BITSTREAM_WIDTH-1:0] out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          out_done,
  output logic [S5_ADDR_WIDTH:0]        out_level,
  output logic                          out_overflow,
  output logic                          out_flag_error
);

  typedef logic [S5_ADDR_WIDTH-1:0] ptr_t;
  typedef logic [S5_ADDR_WIDTH:0]   lvl_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FLUSH, ST_DONE} state_t;

  logic [S5_BITSTREAM_WIDTH-1:0] mem_q [S5_FIFO_DEPTH];
  logic [S5_BITSTREAM_WIDTH-1:0] mem_d [S5_FIFO_DEPTH];
  logic [S5_FIFO_DEPTH-1:0]      tag_q, tag_d;
  ptr_t                          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  lvl_t                          level_q, level_d;
  logic                          overflow_q, overflow_d;
  logic                          flag_error_q, flag_error_d;
  state_t                        state_q, state_d;

  logic [S5_BITSTREAM_WIDTH-1:0] in_bytes [5];
  logic       in_ignored, flag_bad, last_in, drop, accept, pop;
  logic [2:0] n_req, n_acc;
  lvl_t       free_space;
  ptr_t       idx;

  assign in_bytes[0] = in_bit_1;
  assign in_bytes[1] = in_bit_2;
  assign in_bytes[2] = in_bit_3;
  assign in_bytes[3] = in_bit_4;
  assign in_bytes[4] = in_bit_5;

  assign out_valid      = (level_q != '0);
  assign out_byte       = mem_q[rd_ptr_q];
  assign out_last       = tag_q[rd_ptr_q] && out_valid;
  assign out_done       = (state_q == ST_DONE);
  assign out_level      = level_q;
  assign out_overflow   = overflow_q;
  assign out_flag_error = flag_error_q;

  // Decode the input group: ignore it once the frame end is seen, size-check against pre-pop space.
  always_comb begin
    in_ignored = (state_q == ST_FLUSH) || (state_q == ST_DONE);
    flag_bad   = (in_flag > 3'd5);
    n_req      = (in_ignored || flag_bad) ? 3'd0 : in_flag;
    last_in    = in_flag_last && !in_ignored;
    free_space = lvl_t'(S5_FIFO_DEPTH) - level_q;
    drop       = (n_req != 3'd0) && (lvl_t'(n_req) > free_space);
    accept     = (n_req != 3'd0) && !drop;
    n_acc      = accept ? n_req : 3'd0;
    pop        = out_valid && out_ready;
  end

  // FIFO datapath: pop clears the head tag, accepted bytes land at wr_ptr.., frame end tags the newest byte.
  always_comb begin
    mem_d        = mem_q;
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q + ptr_t'(n_acc);
    rd_ptr_d     = rd_ptr_q;
    idx          = '0;
    overflow_d   = overflow_q | drop;
    flag_error_d = flag_error_q | (flag_bad && !in_ignored);
    level_d      = level_q + lvl_t'(n_acc) - lvl_t'(pop);
    if (pop) begin
      tag_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + ptr_t'(1);
    end
    for (int i = 0; i < 5; i++) begin
      if (3'(i) < n_acc) begin
        idx        = wr_ptr_q + ptr_t'(i);
        mem_d[idx] = in_bytes[i];
        tag_d[idx] = last_in && (3'(i) == n_acc - 3'd1);
      end
    end
    // Frame end without new data: tag the newest buffered byte unless it is leaving this cycle.
    if (last_in && !accept && (level_q != '0) && !(pop && (level_q == lvl_t'(1)))) begin
      tag_d[wr_ptr_q - ptr_t'(1)] = 1'b1;
    end
  end

  // Frame FSM: an empty FIFO after the frame end goes straight to DONE, otherwise drain in FLUSH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (last_in) begin
          state_d = (level_d == '0) ? ST_DONE : ST_FLUSH;
        end else if (accept) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_FLUSH: begin
        if (pop && tag_q[rd_ptr_q]) state_d = ST_DONE;
      end
      default: state_d = ST_DONE;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge s5_clk) begin
    if (s5_reset) begin
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      flag_error_q <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      flag_error_q <= flag_error_d;
      state_q      <= state_d;
    end
  end

  // Byte storage carries no reset; contents are only observed while out_valid is high.
  always_ff @(posedge s5_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_stage_5_byte_packer.sv
// Purpose: directed checks of the byte packer: reset, basic group, overflow, wrap-around, frame end, error and reset.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Backpressure: out_ready is driven per scenario (held low, high, or pseudo-random).
module tb_stage_5_byte_packer;

  logic       s5_clk;
  logic       s5_reset;
  logic [7:0] in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5;
  logic [2:0] in_flag;
  logic       in_flag_last;
  logic [7:0] out_byte;
  logic       out_valid, out_ready, out_last, out_done;
  logic [4:0] out_level;
  logic       out_overflow, out_flag_error;

  int vectors = 0;
  int miscompares = 0;

  stage_5_byte_packer dut (
    .s5_clk(s5_clk), .s5_reset(s5_reset),
    .in_bit_1(in_bit_1), .in_bit_2(in_bit_2), .in_bit_3(in_bit_3),
    .in_bit_4(in_bit_4), .in_bit_5(in_bit_5),
    .in_flag(in_flag), .in_flag_last(in_flag_last),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_done(out_done), .out_level(out_level),
    .out_overflow(out_overflow), .out_flag_error(out_flag_error)
  );

  initial s5_clk = 1'b0;
  always #5 s5_clk = ~s5_clk;

  task automatic step();
    @(posedge s5_clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic l, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    in_flag = f; in_flag_last = l;
    in_bit_1 = b1; in_bit_2 = b2; in_bit_3 = b3; in_bit_4 = b4; in_bit_5 = b5;
  endtask

  task automatic idle_in();
    drive(3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    s5_reset = 1'b1;
    idle_in();
    step();
    s5_reset = 1'b0;
  endtask

  task automatic test_reset();
    s5_reset = 1'b1; out_ready = 1'b0; idle_in();
    step(); step();
    s5_reset = 1'b0;
    vectors++;
    if ({out_valid, out_last, out_done, out_overflow, out_flag_error, out_level} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_state got v%b l%b d%b o%b e%b lvl%0d want all 0",
               out_valid, out_last, out_done, out_overflow, out_flag_error, out_level);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hA1; exp_b[1] = 8'hA2; exp_b[2] = 8'hA3;
    do_reset();
    out_ready = 1'b1;
    drive(3'd3, 1'b0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00);
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_byte !== exp_b[i] || out_level !== 5'(3 - i)) begin
        miscompares++;
        $display("FAIL basic_byte%0d got v%b %h lvl%0d want v1 %h lvl%0d",
                 i, out_valid, out_byte, out_level, exp_b[i], 3 - i);
      end
      step();
    end
    vectors++;
    if (out_valid !== 1'b0 || out_level !== 5'd0) begin
      miscompares++;
      $display("FAIL basic_empty got v%b lvl%0d want v0 lvl0", out_valid, out_level);
    end
  endtask

  task automatic test_overflow();
    logic [4:0] exp_lvl [5];
    exp_lvl[0] = 5'd5; exp_lvl[1] = 5'd10; exp_lvl[2] = 5'd15; exp_lvl[3] = 5'd15; exp_lvl[4] = 5'd15;
    do_reset();
    out_ready = 1'b0;
    for (int g = 0; g < 5; g++) begin
      drive(3'd5, 1'b0, 8'(8'hC0 + 8'(g * 5)), 8'h11, 8'h22, 8'h33, 8'h44);
      step();
      idle_in();
      vectors++;
      if (out_level !== exp_lvl[g] || out_overflow !== (g >= 3)) begin
        miscompares++;
        $display("FAIL overflow_grp%0d got lvl%0d ovf%b want lvl%0d ovf%b",
                 g, out_level, out_overflow, exp_lvl[g], (g >= 3));
      end
    end
    vectors++;
    if (out_byte !== 8'hC0) begin
      miscompares++;
      $display("FAIL overflow_head got %h want c0", out_byte);
    end
  endtask

  task automatic test_wrap();
    int sizes [5];
    int wr_idx, rd_idx, mlevel, cyc, n, g;
    logic popping;
    sizes[0] = 3; sizes[1] = 1; sizes[2] = 5; sizes[3] = 2; sizes[4] = 4;
    do_reset();
    wr_idx = 0; rd_idx = 0; mlevel = 0; cyc = 0; g = 0;
    while (rd_idx < 40 && cyc < 1000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      vectors++;
      if (out_level !== 5'(mlevel) || out_valid !== (mlevel != 0)) begin
        miscompares++;
        $display("FAIL wrap_level cyc%0d got lvl%0d v%b want lvl%0d", cyc, out_level, out_valid, mlevel);
      end
      popping = (mlevel != 0) && out_ready;
      if (popping) begin
        vectors++;
        if (out_byte !== 8'(rd_idx)) begin
          miscompares++;
          $display("FAIL wrap_byte got %h want %h", out_byte, 8'(rd_idx));
        end
        rd_idx++;
      end
      idle_in();
      if (wr_idx < 40) begin
        n = sizes[g % 5];
        if (n > 40 - wr_idx) n = 40 - wr_idx;
        if (16 - mlevel >= n) begin
          drive(3'(n), 1'b0, 8'(wr_idx), 8'(wr_idx + 1), 8'(wr_idx + 2), 8'(wr_idx + 3), 8'(wr_idx + 4));
          wr_idx += n; mlevel += n; g++;
        end
      end
      if (popping) mlevel--;
      step();
      cyc++;
    end
    idle_in();
    out_ready = 1'b0;
    vectors++;
    if (rd_idx != 40) begin
      miscompares++;
      $display("FAIL wrap_timeout got %0d bytes want 40", rd_idx);
    end
  endtask

  task automatic test_last_data();
    do_reset();
    out_ready = 1'b1;
    drive(3'd2, 1'b1, 8'h10, 8'h11, 8'h00, 8'h00, 8'h00);
    step();
    idle_in();
    vectors++;
    if (out_byte !== 8'h10 || out_last !== 1'b0 || out_done !== 1'b0) begin
      miscompares++;
      $display("FAIL lastdata_first got %h last%b done%b want 10 last0 done0", out_byte, out_last, out_done);
    end
    step();
    vectors++;
    if (out_byte !== 8'h11 || out_last !== 1'b1 || out_done !== 1'b0) begin
      miscompares++;
      $display("FAIL lastdata_second got %h last%b done%b want 11 last1 done0", out_byte, out_last, out_done);
    end
    step();
    vectors++;
    if (out_done !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lastdata_done got done%b v%b want done1 v0", out_done, out_valid);
    end
    drive(3'd1, 1'b0, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    idle_in();
    vectors++;
    if (out_done !== 1'b1 || out_level !== 5'd0) begin
      miscompares++;
      $display("FAIL lastdata_sticky got done%b lvl%0d want done1 lvl0", out_done, out_level);
    end
  endtask

  task automatic test_last_nodata();
    do_reset();
    out_ready = 1'b0;
    drive(3'd1, 1'b0, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    drive(3'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    idle_in();
    vectors++;
    if (out_byte !== 8'h55 || out_last !== 1'b1 || out_done !== 1'b0 || out_level !== 5'd1) begin
      miscompares++;
      $display("FAIL lastnodata_tag got %h last%b done%b lvl%0d want 55 last1 done0 lvl1",
               out_byte, out_last, out_done, out_level);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if (out_done !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lastnodata_done got done%b v%b want done1 v0", out_done, out_valid);
    end
    do_reset();
    drive(3'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    idle_in();
    vectors++;
    if (out_done !== 1'b1) begin
      miscompares++;
      $display("FAIL lastempty_done got %b want 1", out_done);
    end
  endtask

  task automatic test_error_reset();
    do_reset();
    out_ready = 1'b0;
    drive(3'd7, 1'b0, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
    step();
    idle_in();
    vectors++;
    if (out_level !== 5'd0 || out_valid !== 1'b0 || out_flag_error !== 1'b1) begin
      miscompares++;
      $display("FAIL error_flag got lvl%0d v%b err%b want lvl0 v0 err1", out_level, out_valid, out_flag_error);
    end
    for (int g = 0; g < 4; g++) begin
      drive(3'd5, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
      step();
    end
    drive(3'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    vectors++;
    if (out_overflow !== 1'b1 || out_flag_error !== 1'b1 || out_level !== 5'd15) begin
      miscompares++;
      $display("FAIL error_sticky got ovf%b err%b lvl%0d want ovf1 err1 lvl15", out_overflow, out_flag_error, out_level);
    end
    s5_reset = 1'b1;
    drive(3'd2, 1'b1, 8'hEE, 8'hEF, 8'h00, 8'h00, 8'h00);
    step();
    s5_reset = 1'b0;
    idle_in();
    vectors++;
    if ({out_valid, out_last, out_done, out_overflow, out_flag_error, out_level} !== 10'b0) begin
      miscompares++;
      $display("FAIL midreset_clear got v%b l%b d%b o%b e%b lvl%0d want all 0",
               out_valid, out_last, out_done, out_overflow, out_flag_error, out_level);
    end
    drive(3'd1, 1'b0, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    idle_in();
    vectors++;
    if (out_level !== 5'd1 || out_byte !== 8'h77) begin
      miscompares++;
      $display("FAIL midreset_idle got lvl%0d %h want lvl1 77", out_level, out_byte);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_wrap();
    test_last_data();
    test_last_nodata();
    test_error_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/stage_5_byte_packer.md
STAGE_5_BYTE_PACKER -- requirements
Module: stage_5_byte_packer

Interface
REQ-001 Parameter S5_BITSTREAM_WIDTH, default 8, is the byte width of every input and output byte lane.
REQ-002 Parameter S5_FIFO_DEPTH, default 16, is the FIFO entry count; it SHALL be a power of two and at least 8.
REQ-003 Parameter S5_ADDR_WIDTH, default 4, is log2(S5_FIFO_DEPTH).
REQ-004 Port s5_clk, input, 1 bit, is the single clock; all logic is rising-edge.
REQ-005 Port s5_reset, input, 1 bit, is the synchronous, active-high reset.
REQ-006 Ports in_bit_1 .. in_bit_5, input, S5_BITSTREAM_WIDTH each, are the carry-resolved bytes from stage 4; in_bit_1 is the oldest.
REQ-007 Port in_flag, input, 3 bits, is the number of valid bytes this cycle (0..5), taken from in_bit_1 upward.
REQ-008 Port in_flag_last, input, 1 bit, marks the final group of the frame.
REQ-009 Port out_byte, output, S5_BITSTREAM_WIDTH, is the FIFO head byte.
REQ-010 Port out_valid, output, 1 bit, is high when out_byte holds a valid byte.
REQ-011 Port out_ready, input, 1 bit, is the downstream consumer's accept signal.
REQ-012 Port out_last, output, 1 bit, is high with the final byte of the frame.
REQ-013 Port out_done, output, 1 bit, is high after the frame has fully drained.
REQ-014 Port out_level, output, S5_ADDR_WIDTH+1 bits, is the current FIFO occupancy.
REQ-015 Port out_overflow, output, 1 bit, is a sticky flag for a dropped input group.
REQ-016 Port out_flag_error, output, 1 bit, is a sticky flag for an illegal in_flag value of 6 or 7.

Function
REQ-017 The FIFO SHALL be circular, with wr_ptr and rd_ptr of S5_ADDR_WIDTH bits that wrap modulo S5_FIFO_DEPTH; each entry holds one byte plus one last-tag bit.
REQ-018 The output SHALL be show-ahead: out_valid = (level != 0), out_byte = head entry, out_last = head last-tag AND out_valid.
REQ-019 A pop SHALL occur on a cycle with out_valid && out_ready; it advances rd_ptr by 1 and makes the next byte visible in the following cycle.
REQ-020 A group with in_flag = N (1..5) SHALL be written in one cycle as bytes in_bit_1..in_bit_N at wr_ptr..wr_ptr+N-1 (mod depth), and wr_ptr SHALL advance by N.
REQ-021 Free space SHALL be computed from the pre-pop level, so a simultaneous pop never enables a write.
REQ-022 If N > free space, the whole group SHALL be dropped (no partial write) and out_overflow SHALL be set; any in_flag_last in that cycle still takes effect.
REQ-023 The level update SHALL be level + accepted N - pop, all in the same cycle.
REQ-024 An in_flag value of 6 or 7 SHALL be treated as 0 and SHALL set out_flag_error.
REQ-025 FSM states:
- IDLE: the reset state.
- ACTIVE: entered on the first accepted N > 0 group.
- FLUSH: entered from IDLE or ACTIVE on in_flag_last when the FIFO is non-empty after that cycle's write.
- DONE: entered when the FIFO is empty after the last condition.
REQ-026 On in_flag_last with N > 0 accepted, the last-tag SHALL be set on the entry at wr_ptr+N-1.
REQ-027 On in_flag_last with N = 0 (or a dropped group) and a non-empty FIFO, the last-tag SHALL be set on the entry at wr_ptr-1, unless that entry is popped in the same cycle, in which case the FSM goes to DONE once the FIFO empties.
REQ-028 On in_flag_last with an empty FIFO after the cycle, the FSM SHALL go to DONE on the next edge.
REQ-029 In FLUSH and DONE, in_flag and in_flag_last SHALL be ignored.
REQ-030 In FLUSH, popping the last-tagged byte SHALL move the FSM to DONE.
REQ-031 out_done SHALL be 1 only in DONE, and the FSM SHALL stay in DONE until s5_reset.

Reset
REQ-032 While s5_reset is high, the block SHALL on the next edge clear:
- wr_ptr, rd_ptr and level to 0;
- all last-tags;
- out_overflow and out_flag_error to 0;
- the FSM to IDLE.
As a result out_valid = 0, out_last = 0 and out_done = 0.
REQ-033 The byte storage SHALL need no reset, and out_byte is don't-care while out_valid = 0.
REQ-034 A reset mid-frame SHALL discard all buffered bytes, and inputs in the reset cycle SHALL be ignored.

Verification
REQ-035 Scenario (basic group): reset; in_flag=3 with bytes 0xA1,0xA2,0xA3; out_ready=1 -> out_valid rises the next cycle, bytes come out 0xA1,0xA2,0xA3 on consecutive cycles, and level reads 3,2,1,0.
REQ-036 Scenario (overflow): out_ready=0; write five groups of N=5 into a depth-16 FIFO -> the first three are accepted (level 15), the fourth and fifth are dropped, out_overflow=1, and level stays 15.
REQ-037 Scenario (wrap-around): push and pop 40 sequential bytes 0x00..0x27 in groups of mixed sizes 1..5 with random out_ready -> the output order is exactly 0x00..0x27 with no loss or duplication.
REQ-038 Scenario (last with data): in_flag=2 (0x10,0x11) with in_flag_last=1 -> out_last is high only with 0x11, and out_done=1 the cycle after 0x11 pops.
REQ-039 Scenario (last without data): in_flag=0, in_flag_last=1 after 0x55 is buffered -> 0x55 comes out with out_last=1; with an empty FIFO instead, out_done=1 on the next cycle.
REQ-040 Scenario (error and reset): in_flag=7 -> no write and out_flag_error=1; then s5_reset for one cycle mid-frame -> level=0, out_valid=0, both sticky flags clear, FSM in IDLE.
